// File: rtl/jk_count_driver.sv
// Modulo up/down reference counter that also produces the per-bit J/K excitation
// needed for an external master-slave JK flip-flop bank to follow the count.
module jk_count_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             load_ack
);

  // One extra bit keeps MODULUS = 2**WIDTH representable for the compares.
  localparam logic [WIDTH:0] MAX_COUNT = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   q_nxt_ext;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;

  assign q_ext    = {1'b0, q};
  assign load_ext = {1'b0, load_val};

  always_comb begin
    q_nxt_ext = q_ext;
    if (load) begin
      q_nxt_ext = (load_ext > MAX_COUNT) ? MAX_COUNT : load_ext;
    end else if (en && up) begin
      q_nxt_ext = (q_ext == MAX_COUNT) ? '0 : q_ext + 1'b1;
    end else if (en) begin
      q_nxt_ext = (q_ext == '0) ? MAX_COUNT : q_ext - 1'b1;
    end
  end

  assign q_nxt = q_nxt_ext[WIDTH-1:0];

  // Only changing bits get excitation; holding bits resolve their don't-cares to 0.
  assign j_nxt = ~q & q_nxt;
  assign k_nxt = q & ~q_nxt;

  always_ff @(posedge clk) begin
    if (clear) begin
      q        <= '0;
      j        <= '0;
      k        <= '1;
      load_ack <= 1'b0;
    end else begin
      q        <= q_nxt;
      j        <= j_nxt;
      k        <= k_nxt;
      load_ack <= load;
    end
  end

  assign tc = en & ((up & (q_ext == MAX_COUNT)) | (~up & (q_ext == '0)));

endmodule
